// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
//   N      : number of requesters / mux inputs
//   SEL_W  : width of the mux select
//   state_t: arbiter FSM states
//   onehot : select index -> one-hot grant vector
package mux_arb_pkg;

    localparam int N     = 8;
    localparam int SEL_W = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [N-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester-side bundle of the arbiter.
//   req   : per-requester level request
//   din   : per-requester data bit (mux inputs)
//   gnt   : registered one-hot grant
//   sel   : registered mux select
//   valid : registered, high while a grant is active
//   out   : din[sel] gated by valid
// master = requesters, slave = arbiter.
interface mux8_rr_arbiter_if;
    import mux_arb_pkg::*;

    logic [N-1:0]     req;
    logic [N-1:0]     din;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] sel;
    logic             valid;
    logic             out;

    modport master (output req, output din, input gnt, input sel, input valid, input out);
    modport slave  (input req, input din, output gnt, output sel, output valid, output out);

endinterface

// File: rtl/mux8_rr_arbiter_rr_next_sel.sv
// Round-robin pick: first asserted request at or after ptr (mod N).
//   req   : request vector
//   ptr   : highest-priority index
//   found : any request asserted
//   pick  : index of the winning request (ptr when none)
module rr_next_sel
    import mux_arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] pick
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    always_comb begin
        // Rotate so that req[ptr] lands at bit 0, then lowest set bit wins.
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        found = |rot;
        pick  = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) pick = ptr + SEL_W'(i);  // un-rotate; wraps mod N
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter in front of an 8:1 single-bit mux.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : requester bundle (req/din in, gnt/sel/valid/out out)
// A grant lasts until its request drops or MAX_HOLD cycles elapse; on release
// the next winner is searched starting just after the released index and is
// granted on the following edge with no idle gap.
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mux8_rr_arbiter_if.slave   bus
);

    localparam int              HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  ptr, ptr_nxt;
    logic [SEL_W-1:0]  sel_q, sel_nxt;
    logic [N-1:0]      gnt_q, gnt_nxt;
    logic              valid_q, valid_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;

    logic [SEL_W-1:0]  srch_ptr, pick;
    logic              found, rel, load;

    // Release of the current grant, and where the next search starts. On
    // release the search begins at sel+1 even though ptr is only updated at
    // the edge, so the handoff happens in the same cycle.
    always_comb begin
        rel      = (state == GRANT) && (!bus.req[sel_q] || hold_cnt == HOLD_LAST);
        srch_ptr = (state == GRANT) ? sel_q + SEL_W'(1) : ptr;
    end

    rr_next_sel u_next (
        .req   (bus.req),
        .ptr   (srch_ptr),
        .found (found),
        .pick  (pick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = GRANT;
            GRANT:   if (rel)   state_nxt = found ? GRANT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        load      = found && ((state == IDLE) || rel);
        ptr_nxt   = rel ? sel_q + SEL_W'(1) : ptr;
        sel_nxt   = load ? pick : sel_q;
        gnt_nxt   = gnt_q;
        valid_nxt = valid_q;
        hold_nxt  = hold_cnt;
        if (load) begin
            gnt_nxt   = onehot(pick);
            valid_nxt = 1'b1;
            hold_nxt  = '0;
        end else if (rel) begin
            gnt_nxt   = '0;
            valid_nxt = 1'b0;
            hold_nxt  = '0;
        end else if (state == GRANT) begin
            hold_nxt  = hold_cnt + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            sel_q    <= '0;
            gnt_q    <= '0;
            valid_q  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            ptr      <= ptr_nxt;
            sel_q    <= sel_nxt;
            gnt_q    <= gnt_nxt;
            valid_q  <= valid_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;
    assign bus.out   = valid_q ? bus.din[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;
    import mux_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    mux8_rr_arbiter_if bus();

    mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Structural invariants, sampled away from the active edge.
    always @(negedge clk) begin
        n_cmp++;
        if (!$onehot0(bus.gnt)) begin
            n_err++;
            $display("FAIL inv_onehot: gnt=%b not one-hot-or-zero", bus.gnt);
        end
        n_cmp++;
        if (bus.valid !== (|bus.gnt)) begin
            n_err++;
            $display("FAIL inv_valid: valid=%b required %b", bus.valid, |bus.gnt);
        end
        n_cmp++;
        if (bus.gnt[bus.sel] !== bus.valid) begin
            n_err++;
            $display("FAIL inv_gnt_sel: gnt[sel]=%b required %b", bus.gnt[bus.sel], bus.valid);
        end
        n_cmp++;
        if (bus.out !== (bus.valid & bus.din[bus.sel])) begin
            n_err++;
            $display("FAIL inv_out: out=%b required %b", bus.out, bus.valid & bus.din[bus.sel]);
        end
    end

    task automatic reset_dut();
        rst_n   = 1'b0;
        bus.req = '0;
        bus.din = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 8'hFF;
        bus.din = 8'hFF;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.gnt !== 8'h00 || bus.sel !== 3'd0 || bus.valid !== 1'b0 || bus.out !== 1'b0) begin
            n_err++;
            $display("FAIL reset: gnt=%h sel=%0d valid=%b out=%b required 00/0/0/0",
                     bus.gnt, bus.sel, bus.valid, bus.out);
        end
    endtask

    task automatic test_single();
        reset_dut();
        bus.req = 8'b0000_0100;
        #1;
        n_cmp++;
        if (bus.valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_latency: valid=%b required 0 before edge", bus.valid);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.gnt !== 8'b0000_0100 || bus.sel !== 3'd2 || bus.valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: gnt=%b sel=%0d valid=%b required 00000100/2/1",
                     bus.gnt, bus.sel, bus.valid);
        end
        bus.din = 8'hFB;
        #1;
        n_cmp++;
        if (bus.out !== 1'b0) begin
            n_err++;
            $display("FAIL single_out0: out=%b required 0", bus.out);
        end
        bus.din = 8'h04;
        #1;
        n_cmp++;
        if (bus.out !== 1'b1) begin
            n_err++;
            $display("FAIL single_out1: out=%b required 1", bus.out);
        end
        bus.req = '0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.gnt !== 8'h00 || bus.out !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: valid=%b gnt=%h out=%b required 0/00/0",
                     bus.valid, bus.gnt, bus.out);
        end
    endtask

    task automatic test_rr_all();
        logic [SEL_W-1:0] es;
        reset_dut();
        bus.req = 8'hFF;
        bus.din = 8'hA5;
        for (int g = 0; g < 9; g++) begin
            es = SEL_W'(g % 8);
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                #1;
                n_cmp++;
                if (bus.sel !== es || bus.gnt !== onehot(es) || bus.valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL rr_all g%0d c%0d: sel=%0d gnt=%b valid=%b required sel=%0d valid=1",
                             g, c, bus.sel, bus.gnt, bus.valid, es);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [SEL_W-1:0] es;
        reset_dut();
        bus.req = 8'b1000_0001;
        for (int g = 0; g < 4; g++) begin
            es = (g % 2 == 1) ? 3'd7 : 3'd0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                #1;
                n_cmp++;
                if (bus.sel !== es || bus.valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL wrap g%0d c%0d: sel=%0d valid=%b required sel=%0d valid=1",
                             g, c, bus.sel, bus.valid, es);
                end
            end
        end
    endtask

    task automatic test_sole_hold();
        logic [1:0] eh;
        reset_dut();
        bus.req = 8'b0000_1000;
        for (int k = 0; k < 12; k++) begin
            eh = 2'(k % 4);
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.sel !== 3'd3 || bus.valid !== 1'b1 || dut.hold_cnt !== eh) begin
                n_err++;
                $display("FAIL sole_hold k%0d: sel=%0d valid=%b hold=%0d required 3/1/%0d",
                         k, bus.sel, bus.valid, dut.hold_cnt, eh);
            end
        end
    endtask

    task automatic test_drop();
        reset_dut();
        bus.req = 8'b0010_0010;
        bus.din = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.sel !== 3'd1 || bus.valid !== 1'b1) begin
            n_err++;
            $display("FAIL drop_first: sel=%0d valid=%b required 1/1", bus.sel, bus.valid);
        end
        bus.req = 8'b0010_0000;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.gnt !== 8'b0010_0000 || bus.sel !== 3'd5 || bus.valid !== 1'b1) begin
            n_err++;
            $display("FAIL drop_handoff: gnt=%b sel=%0d valid=%b required 00100000/5/1",
                     bus.gnt, bus.sel, bus.valid);
        end
        bus.req = '0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.gnt !== 8'h00 || bus.out !== 1'b0 || bus.sel !== 3'd5) begin
            n_err++;
            $display("FAIL drop_idle: valid=%b gnt=%h out=%b sel=%0d required 0/00/0/5",
                     bus.valid, bus.gnt, bus.out, bus.sel);
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        bus.req = 8'hFF;
        bus.din = 8'hFF;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.sel !== 3'd2 || bus.valid !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre: sel=%0d valid=%b required 2/1", bus.sel, bus.valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.gnt !== 8'h00 || bus.valid !== 1'b0 || bus.out !== 1'b0 || bus.sel !== 3'd0) begin
            n_err++;
            $display("FAIL areset_now: gnt=%h valid=%b out=%b sel=%0d required 00/0/0/0",
                     bus.gnt, bus.valid, bus.out, bus.sel);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.gnt !== 8'h01 || bus.sel !== 3'd0 || bus.valid !== 1'b1) begin
            n_err++;
            $display("FAIL areset_after: gnt=%b sel=%0d valid=%b required 00000001/0/1",
                     bus.gnt, bus.sel, bus.valid);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.req = '0;
        bus.din = '0;
        test_reset();
        test_single();
        test_rr_all();
        test_wrap();
        test_sole_hold();
        test_drop();
        test_async_reset();
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
